instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage feeding the execute/ALU stage of the 5-stage CPU.
//  Holds the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
//  Buffers returned words in a 2-entry FIFO so the downstream IR handshake can stall without losing data.
//  Supports PC redirect (jump/branch from a later stage) and a halt request.
// PARAMETERS
//  ADDR_W    5   PC / imem address width (2^ADDR_W instruction words)
//  INSTR_W   32  instruction word width (IR: [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm, [15:0] isrc)
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk             in   1        clock, all state updates on rising edge
//  rst             in   1        asynchronous, active-high reset
//  imem_rd_en      out  1        read strobe to instruction memory
//  imem_addr       out  ADDR_W   read address; equals current PC
//  imem_rdata      in   INSTR_W  read data, valid the cycle after imem_rd_en=1
//  redirect_valid  in   1        load redirect_pc, flush buffered/in-flight words
//  redirect_pc     in   ADDR_W   new fetch address
//  halt            in   1        level: stop issuing new reads while high
//  ir_valid        out  1        ir_out/ir_pc hold a valid instruction
//  ir_ready        in   1        execute stage accepts (transfer = ir_valid & ir_ready)
//  ir_out          out  INSTR_W  instruction word (head of FIFO, registered)
//  ir_pc           out  ADDR_W   address the instruction was fetched from
// BEHAVIOUR
//  Reset (async, any time, incl. mid-fetch):
//   - pc=RESET_PC, FIFO empty, in-flight flag 0, state IDLE.
//   - ir_valid=0, imem_rd_en=0, ir_out=0, ir_pc=0.
//   - imem_addr=RESET_PC.
//  FSM:
//   - IDLE -> FETCH: always, one cycle after reset release.
//   - FETCH -> HALT: when halt=1.
//   - HALT -> FETCH: when halt=0.
//  Issue rule (combinational): imem_rd_en = (state==FETCH) & ~halt & ~redirect_valid & (count + inflight - pop < 2).
//   - pop = ir_valid & ir_ready.
//   - count = FIFO occupancy 0..2; inflight = read issued last cycle.
//  On issue: pc <= pc+1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0, no flag); inflight <= 1; tag <= pc.
//  Return: the cycle after issue, {imem_rdata, tag} is pushed at the clock edge.
//   - Push and pop in the same cycle leave count unchanged.
//   - Overflow cannot occur by construction; assert count<=2.
//  Output: ir_valid = count!=0; ir_out/ir_pc = head entry, stable while ir_valid & ~ir_ready.
//  Latency: rst release at edge E0.
//   - IDLE during cycle 0; first rd_en (addr RESET_PC) in cycle 1.
//   - ir_valid=1 in cycle 3.
//   - Sustained 1 instr/cycle while ir_ready=1 and halt=0.
//  Redirect (highest priority, any state):
//   - Next edge: pc <= redirect_pc, FIFO cleared, in-flight return squashed (not pushed).
//   - ir_valid=0 the following cycle.
//   - Issue from redirect_pc resumes the cycle after redirect; no issue during the redirect cycle.
//   - A pop in the redirect cycle still completes (downstream took it).
//  Halt:
//   - No new issues while high.
//   - An in-flight read still lands in the FIFO; the FIFO keeps draining.
//   - Redirect during HALT updates pc and flushes; fetch restarts from it on halt=0.
//  Simultaneous halt and redirect: redirect applied, state -> HALT.
// TESTING
//  1 Reset, ir_ready=1, imem[k]=k+100: imem_addr 0,1,2.. from cycle 1; ir_valid cycle 3; ir_out 100,101,102 back-to-back with ir_pc 0,1,2.
//  2 Backpressure: ir_ready=0 for 5 cycles mid-stream: count stops at 2, rd_en=0, ir_out held; release -> no word lost or duplicated.
//  3 Redirect to 20 while FIFO full and read in flight: next cycle ir_valid=0; next delivered word is imem[20] with ir_pc=20.
//  4 Wrap: redirect_pc=31 -> delivered ir_pc sequence 31,0,1 with matching data.
//  5 Halt for 4 cycles with one read in flight: that word delivered, no further rd_en; halt=0 resumes at next sequential pc.
//  6 rst asserted mid-stream (async, between edges): outputs immediately cleared; restart fetches RESET_PC per scenario 1 timing.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues 1-cycle-latency instruction memory reads and
// buffers returned words in a 2-entry FIFO ahead of the IR handshake.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 5,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   tag;
  logic                inflight;
  logic [INSTR_W-1:0]  data_q [2];
  logic [ADDR_W-1:0]   tag_q  [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;
  logic [2:0]          occ;
  logic                pop;
  logic                issue_ok;

  assign pop      = ir_valid & ir_ready;
  // Slots already claimed once this cycle's pop retires: buffered plus in flight.
  assign occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue_ok = occ < 3'd2;

  assign imem_addr = pc;
  assign ir_valid  = count != 2'd0;
  assign ir_out    = data_q[rd_ptr];
  assign ir_pc     = tag_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (halt) state_nxt = S_HALT;
      S_HALT:  if (!halt) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
    if (redirect_valid && halt) begin
      state_nxt = S_HALT;
    end
  end

  always_comb begin
    imem_rd_en = (state == S_FETCH) & ~halt & ~redirect_valid & issue_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      if (imem_rd_en) begin
        pc  <= pc + ADDR_W'(1);
        tag <= pc;
      end
      inflight <= imem_rd_en;
    end
  end

  // A redirect squashes the returning word and drops the buffer; a pop in that
  // cycle has already been taken downstream so nothing is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) begin
        data_q[wr_ptr] <= imem_rdata;
        tag_q[wr_ptr]  <= tag;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count != 2'd3);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed table, multi-cycle corner
// sequences and a randomized run against a queue-based behavioural model.
module tb_instr_fetch_stage;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 32;

  logic               clk;
  logic               rst;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_out;
  logic [ADDR_W-1:0]  ir_pc;

  instr_fetch_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(5'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_out        (ir_out),
    .ir_pc         (ir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [INSTR_W-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur at %0t", name, $time);
  endtask

  // Behavioural model: a queue of words that have landed, plus the one read in flight.
  typedef struct {
    logic [INSTR_W-1:0] d;
    logic [ADDR_W-1:0]  p;
  } ent_t;

  ent_t              q[$];
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_tag;
  bit                m_inflight;
  bit                m_prev_halt;
  int                m_cyc;
  int                clean_run;

  // Values sampled at the last negedge, for directed checks.
  logic               s_rd;
  logic [ADDR_W-1:0]  s_addr;
  logic               s_valid;
  logic [ADDR_W-1:0]  s_pc;
  logic [INSTR_W-1:0] s_out;
  logic [ADDR_W-1:0]  last_issue;
  logic [ADDR_W-1:0]  xfer_pc[$];
  logic [INSTR_W-1:0] xfer_out[$];

  task automatic model_reset();
    q.delete();
    m_pc        = 5'd0;
    m_tag       = 5'd0;
    m_inflight  = 1'b0;
    m_prev_halt = 1'b0;
    m_cyc       = 0;
    clean_run   = 0;
  endtask

  task automatic cycle();
    bit                pop;
    bit                exp_rd;
    bit                redir;
    bit                hlt;
    logic [ADDR_W-1:0] rpc;
    int                occ;
    @(negedge clk);
    redir  = redirect_valid;
    hlt    = halt;
    rpc    = redirect_pc;
    pop    = ir_ready && (q.size() != 0);
    occ    = int'(q.size()) + int'(m_inflight) - int'(pop);
    exp_rd = (m_cyc >= 1) && !m_prev_halt && !hlt && !redir && (occ < 2);
    s_rd = imem_rd_en; s_addr = imem_addr; s_valid = ir_valid; s_pc = ir_pc; s_out = ir_out;
    chk("m_valid", ir_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_ir_pc", ir_pc, q[0].p);
      chk("m_ir_out", ir_out, q[0].d);
    end
    chk("m_rd_en", imem_rd_en, exp_rd);
    chk("m_addr", imem_addr, m_pc);
    if (!hlt && !redir && ir_ready) clean_run++;
    else clean_run = 0;
    if (clean_run >= 4) chk("m_throughput", ir_valid, 1'b1);
    if (ir_valid && ir_ready) begin
      xfer_pc.push_back(ir_pc);
      xfer_out.push_back(ir_out);
    end
    if (imem_rd_en) last_issue = imem_addr;
    @(posedge clk);
    if (redir) begin
      q.delete();
      m_pc       = rpc;
      m_inflight = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_inflight) q.push_back('{mem[m_tag], m_tag});
      if (exp_rd) begin
        m_tag = m_pc;
        m_pc  = m_pc + 5'd1;
      end
      m_inflight = exp_rd;
    end
    m_prev_halt = hlt;
    m_cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    #1;
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_rd_en", imem_rd_en, 1'b0);
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_ir_pc", ir_pc, 5'd0);
    chk("rst_addr", imem_addr, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit                redir;
    logic [ADDR_W-1:0] rpc;
    bit                e_rd;
    logic [ADDR_W-1:0] e_addr;
    bit                e_valid;
    logic [ADDR_W-1:0] e_pc;
    logic [31:0]       e_out;
  } vec_t;

  vec_t tbl[13];

  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) begin
      ir_ready       = 1'b1;
      halt           = 1'b0;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      cycle();
      chk($sformatf("t%0d_rd_en", i), s_rd, tbl[i].e_rd);
      chk($sformatf("t%0d_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_ir_pc", i), s_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_ir_out", i), s_out, tbl[i].e_out);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [INSTR_W-1:0] held;
    logic [ADDR_W-1:0]  l_pc;
    bit                 seen;

    //          redir rpc   rd  addr  valid pc   out
    tbl[0]  = '{0, 5'd0,  0, 5'd0,  0, 5'd0,  0};
    tbl[1]  = '{0, 5'd0,  1, 5'd0,  0, 5'd0,  0};
    tbl[2]  = '{0, 5'd0,  1, 5'd1,  0, 5'd0,  0};
    tbl[3]  = '{0, 5'd0,  1, 5'd2,  1, 5'd0,  100};
    tbl[4]  = '{0, 5'd0,  1, 5'd3,  1, 5'd1,  101};
    tbl[5]  = '{0, 5'd0,  1, 5'd4,  1, 5'd2,  102};
    tbl[6]  = '{0, 5'd0,  1, 5'd5,  1, 5'd3,  103};
    tbl[7]  = '{1, 5'd31, 0, 5'd6,  1, 5'd4,  104};
    tbl[8]  = '{0, 5'd0,  1, 5'd31, 0, 5'd0,  0};
    tbl[9]  = '{0, 5'd0,  1, 5'd0,  0, 5'd0,  0};
    tbl[10] = '{0, 5'd0,  1, 5'd1,  1, 5'd31, 131};
    tbl[11] = '{0, 5'd0,  1, 5'd2,  1, 5'd0,  100};
    tbl[12] = '{0, 5'd0,  1, 5'd3,  1, 5'd1,  101};

    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k + 100);
    rst = 1'b0; ir_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    do_reset();

    // Startup latency, streaming and PC wrap after redirect to 31.
    run_table(13);

    // Backpressure: buffer fills, issue stops, head word is held.
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) held = s_out;
      else begin
        chk("bp_rd_en", s_rd, 1'b0);
        chk("bp_valid", s_valid, 1'b1);
        chk("bp_hold", s_out, held);
      end
    end
    xfer_pc.delete(); xfer_out.delete();
    ir_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_xfer_count", xfer_pc.size(), 8);
    for (int i = 0; i < 8 && i < xfer_pc.size(); i++)
      chk($sformatf("bp_xfer_pc%0d", i), xfer_pc[i], 5'(2 + i));

    // Redirect to 20 with the buffer full.
    ir_ready = 1'b0;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 5'd20;
    cycle();
    redirect_valid = 1'b0; ir_ready = 1'b1;
    xfer_pc.delete(); xfer_out.delete();
    cycle();
    chk("redir_valid_drop", s_valid, 1'b0);
    for (int i = 0; i < 10 && xfer_pc.size() == 0; i++) cycle();
    if (xfer_pc.size() == 0) fail_now("redir_first_word");
    else begin
      chk("redir_first_pc", xfer_pc[0], 5'd20);
      chk("redir_first_out", xfer_out[0], 32'd120);
    end

    // Halt for 4 cycles with a read in flight.
    repeat (3) cycle();
    l_pc = last_issue;
    halt = 1'b1;
    xfer_pc.delete(); xfer_out.delete();
    repeat (4) begin
      cycle();
      chk("halt_no_issue", s_rd, 1'b0);
    end
    if (xfer_pc.size() == 0) fail_now("halt_inflight_word");
    else chk("halt_inflight_pc", xfer_pc[$], l_pc);
    halt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (s_rd) begin
        seen = 1'b1;
        chk("halt_resume_addr", s_addr, 5'(l_pc + 5'd1));
      end
    end
    if (!seen) fail_now("halt_resume_issue");

    // Asynchronous reset mid-stream, then startup timing again.
    repeat (4) cycle();
    #2;
    do_reset();
    run_table(7);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      ir_ready = ($urandom_range(9) < 7);
      if (m_cyc == 0) halt = 1'b0;
      else if ($urandom_range(19) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = 5'($urandom);
      cycle();
    end
    redirect_valid = 1'b0; halt = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
